mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds HI/LO, runs a fixed-latency mult (5 cycles)
// or div (10 cycles) on operands captured at start, and raises the pipeline stall.
//
// state  | meaning
// S_IDLE | waiting for start / mthi / mtlo; HI/LO writable directly
// S_RUN  | operation in flight, cnt counts down to the write-back edge
module mdu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        isMD_D,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed division via magnitudes: truncation toward zero falls out naturally,
    // and 0x80000000 / -1 yields 0x80000000 rem 0 without a special case.
    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[31];
    assign b_neg      = div_signed & b_q[31];
    assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
    assign q_mag      = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
    assign r_mag      = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start && (md_op >= OP_MULT) && (md_op <= OP_DIVU)) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = md_op;
                    cnt_d   = (md_op == OP_MULT || md_op == OP_MULTU) ? 4'd5 : 4'd10;
                    state_d = S_RUN;
                end else if (md_op == OP_MTHI) begin
                    hi_d = A;
                end else if (md_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_stall = isMD_D & (start | busy_q);

endmodule
